// File: rtl/pe_program_loader.sv
// -----------------------------------------------------------------------------
// pe_program_loader
//
// Upstream programming stage for the PE mesh. A pass is opened with prog_start
// (prog_count records long). Each accepted configuration record becomes a
// one-cycle load strobe to the addressed PE. The instruction and data of the
// record are broadcast to every PE on the same cycle. Once the last record has
// been issued, the loader waits a settle window and then releases the mesh
// into compute (mesh_run).
//
// Ports
//   clk              in   1       rising-edge clock
//   reset            in   1       asynchronous, active-low reset
//   prog_start       in   1       request a new programming pass
//   prog_count       in   8       records in the pass, sampled with prog_start
//   cfg_valid        in   1       record valid
//   cfg_ready        out  1       record accepted this cycle (state == LOAD)
//   cfg_pe_id        in   ID_W    target PE index
//   cfg_instruction  in   4       PE instruction word
//   cfg_data         in   32      PE internal data value
//   pe_load          out  NUM_PE  one-hot load strobe, bit i loads PE i
//   pe_instruction   out  4       broadcast instruction
//   pe_data          out  32      broadcast internal data
//   mesh_run         out  1       mesh configured and computing
//   prog_busy        out  1       high in LOAD or SETTLE
//   prog_done        out  1       one-cycle pulse on entry to RUN
//   id_error         out  1       sticky: a record addressed a PE >= NUM_PE
//
// State table
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | after reset, waiting for the first prog_start
//   S_LOAD   | accepting records, cfg_ready high, remaining counts down
//   S_SETTLE | settle window after the last record, settle_cnt counts down
//   S_RUN    | mesh released, mesh_run high, a new prog_start reprograms
// -----------------------------------------------------------------------------
module pe_program_loader #(
  parameter int NUM_PE        = 16,
  parameter int ID_W          = $clog2(NUM_PE),
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_start,
  input  logic [7:0]        prog_count,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ID_W-1:0]   cfg_pe_id,
  input  logic [3:0]        cfg_instruction,
  input  logic [31:0]       cfg_data,
  output logic [NUM_PE-1:0] pe_load,
  output logic [3:0]        pe_instruction,
  output logic [31:0]       pe_data,
  output logic              mesh_run,
  output logic              prog_busy,
  output logic              prog_done,
  output logic              id_error
);

  // Settle counter is loaded with SETTLE_CYCLES-1 and runs down to zero.
  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]  remaining, remaining_nxt;
  logic [SW-1:0] settle_cnt, settle_cnt_nxt;

  logic handshake;
  logic start_ok;
  logic id_bad;

  logic [NUM_PE-1:0] pe_load_nxt;
  logic [3:0]        pe_instruction_nxt;
  logic [31:0]       pe_data_nxt;
  logic              mesh_run_nxt;
  logic              prog_busy_nxt;
  logic              prog_done_nxt;
  logic              id_error_nxt;

  // cfg_ready is the only combinational output.
  assign cfg_ready = (state == S_LOAD);
  assign handshake = cfg_valid & cfg_ready;

  // A start request is honoured only from IDLE or RUN and only for a
  // non-empty pass; otherwise it is dropped without any side effect.
  assign start_ok = prog_start && (prog_count != 8'd0) &&
                    ((state == S_IDLE) || (state == S_RUN));

  assign id_bad = (int'(cfg_pe_id) >= NUM_PE);

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      remaining  <= 8'd0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    remaining_nxt  = remaining;
    settle_cnt_nxt = settle_cnt;

    case (state)
      S_IDLE, S_RUN: begin
        if (start_ok) begin
          state_nxt     = S_LOAD;
          remaining_nxt = prog_count;
        end
      end

      S_LOAD: begin
        if (handshake) begin
          remaining_nxt = remaining - 8'd1;
          // The record that empties the pass opens the settle window; its
          // load pulse lands in the first SETTLE cycle.
          if (remaining == 8'd1) begin
            state_nxt      = S_SETTLE;
            settle_cnt_nxt = SW'(SETTLE_CYCLES - 1);
          end
        end
      end

      S_SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt = S_RUN;
        end else begin
          settle_cnt_nxt = settle_cnt - SW'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pe_load_nxt        = '0;
    pe_instruction_nxt = pe_instruction;
    pe_data_nxt        = pe_data;
    id_error_nxt       = id_error;

    for (int i = 0; i < NUM_PE; i++) begin
      pe_load_nxt[i] = handshake && !id_bad && (int'(cfg_pe_id) == i);
    end

    // Broadcast lines follow every accepted record, including ones with an
    // out-of-range id; they hold between loads.
    if (handshake) begin
      pe_instruction_nxt = cfg_instruction;
      pe_data_nxt        = cfg_data;
      if (id_bad) begin
        id_error_nxt = 1'b1;
      end
    end

    if (start_ok) begin
      id_error_nxt = 1'b0;
    end

    mesh_run_nxt  = (state_nxt == S_RUN);
    prog_busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_SETTLE);
    prog_done_nxt = (state_nxt == S_RUN) && (state != S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_load        <= '0;
      pe_instruction <= 4'd0;
      pe_data        <= 32'd0;
      mesh_run       <= 1'b0;
      prog_busy      <= 1'b0;
      prog_done      <= 1'b0;
      id_error       <= 1'b0;
    end else begin
      pe_load        <= pe_load_nxt;
      pe_instruction <= pe_instruction_nxt;
      pe_data        <= pe_data_nxt;
      mesh_run       <= mesh_run_nxt;
      prog_busy      <= prog_busy_nxt;
      prog_done      <= prog_done_nxt;
      id_error       <= id_error_nxt;
    end
  end

endmodule

// File: tb/tb_pe_program_loader.sv
// -----------------------------------------------------------------------------
// tb_pe_program_loader
//
// Drives programming passes into pe_program_loader and checks the load pulses,
// broadcast values, sticky id error and the RUN release timing against a
// record-level reference model kept in queues.
// ID_W is widened to 5 so that out-of-range PE ids can be presented.
// -----------------------------------------------------------------------------
module tb_pe_program_loader;

  localparam int NUM_PE = 16;
  localparam int ID_W   = 5;
  localparam int S      = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              prog_start = 1'b0;
  logic [7:0]        prog_count = 8'd0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [ID_W-1:0]   cfg_pe_id = '0;
  logic [3:0]        cfg_instruction = 4'd0;
  logic [31:0]       cfg_data = 32'd0;
  logic [NUM_PE-1:0] pe_load;
  logic [3:0]        pe_instruction;
  logic [31:0]       pe_data;
  logic              mesh_run;
  logic              prog_busy;
  logic              prog_done;
  logic              id_error;

  pe_program_loader #(
    .NUM_PE(NUM_PE),
    .ID_W(ID_W),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .reset(reset),
    .prog_start(prog_start),
    .prog_count(prog_count),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_pe_id(cfg_pe_id),
    .cfg_instruction(cfg_instruction),
    .cfg_data(cfg_data),
    .pe_load(pe_load),
    .pe_instruction(pe_instruction),
    .pe_data(pe_data),
    .mesh_run(mesh_run),
    .prog_busy(prog_busy),
    .prog_done(prog_done),
    .id_error(id_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] vec;
    logic [3:0]  ins;
    logic [31:0] dat;
    logic        err;
  } item_t;

  item_t load_q[$];
  int    done_q[$];

  // Reference model state: pass open, records still owed, sticky error.
  bit   model_active = 1'b0;
  int   model_rem = 0;
  logic model_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected record when its pulse cycle comes up and the
  // expected RUN entry when prog_done is seen.
  always @(negedge clk) begin
    item_t it;
    int    e;
    if (reset) begin
      if (load_q.size() > 0 && load_q[0].cyc == cyc) begin
        it = load_q.pop_front();
        check("pe_load", 64'(pe_load), 64'(it.vec));
        check("pe_onehot0", 64'($onehot0(pe_load)), 64'd1);
        check("pe_instruction", 64'(pe_instruction), 64'(it.ins));
        check("pe_data", 64'(pe_data), 64'(it.dat));
        check("id_error", 64'(id_error), 64'(it.err));
        check("busy_at_load", 64'(prog_busy), 64'd1);
      end else if (pe_load != '0) begin
        check("pe_load_spurious", 64'(pe_load), 64'd0);
      end
      if (prog_done) begin
        if (done_q.size() == 0) begin
          check("prog_done_spurious", 64'd1, 64'd0);
        end else begin
          e = done_q.pop_front();
          check("prog_done_cycle", 64'(cyc), 64'(e));
          check("run_at_done", 64'(mesh_run), 64'd1);
          check("busy_at_done", 64'(prog_busy), 64'd0);
        end
      end
    end
  end

  // Called in the posedge+1 phase; returns in the posedge+1 phase of the
  // cycle after prog_start was sampled.
  task automatic start_pass(input int cnt);
    prog_start = 1'b1;
    prog_count = cnt[7:0];
    @(negedge clk);
    if (!model_active && cnt != 0) begin
      model_active = 1'b1;
      model_rem    = cnt;
      model_err    = 1'b0;
    end
    @(posedge clk);
    #1;
    prog_start = 1'b0;
  endtask

  task automatic send_record(input logic [ID_W-1:0] id, input logic [3:0] ins,
                             input logic [31:0] dat, input int gap);
    item_t       it;
    logic [15:0] one;
    bit          bad;
    one = 16'h0001;
    repeat (gap) begin
      @(negedge clk);
      check("ready_while_idle_valid", 64'(cfg_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    cfg_valid       = 1'b1;
    cfg_pe_id       = id;
    cfg_instruction = ins;
    cfg_data        = dat;
    @(negedge clk);
    check("cfg_ready_in_load", 64'(cfg_ready), 64'd1);
    if (cfg_ready) begin
      bad       = (int'(id) >= NUM_PE);
      model_err = model_err | bad;
      it.cyc    = cyc + 1;
      it.vec    = bad ? 16'h0000 : (one << id);
      it.ins    = ins;
      it.dat    = dat;
      it.err    = model_err;
      load_q.push_back(it);
      model_rem--;
      if (model_rem == 0) begin
        done_q.push_back(cyc + 1 + S);
        model_active = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!mesh_run && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("run_reached", 64'(mesh_run), 64'd1);
    @(posedge clk);
    #1;
    check("run_held", 64'(mesh_run), 64'd1);
    check("busy_in_run", 64'(prog_busy), 64'd0);
    check("ready_in_run", 64'(cfg_ready), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);
    check("load_q_drained", 64'(load_q.size()), 64'd0);
  endtask

  initial begin
    // Reset values while reset is asserted.
    #1;
    check("rst_pe_load", 64'(pe_load), 64'd0);
    check("rst_pe_instruction", 64'(pe_instruction), 64'd0);
    check("rst_pe_data", 64'(pe_data), 64'd0);
    check("rst_mesh_run", 64'(mesh_run), 64'd0);
    check("rst_prog_busy", 64'(prog_busy), 64'd0);
    check("rst_prog_done", 64'(prog_done), 64'd0);
    check("rst_id_error", 64'(id_error), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    #21;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_cfg_ready", 64'(cfg_ready), 64'd0);

    // Two back-to-back records.
    start_pass(2);
    check("load_busy", 64'(prog_busy), 64'd1);
    check("load_ready", 64'(cfg_ready), 64'd1);
    send_record(5'd3, 4'h0, 32'h0000_AAAA, 0);
    send_record(5'd5, 4'h1, 32'h0000_5555, 0);
    wait_run();

    // Same pass with a three-cycle stall before the first record.
    start_pass(2);
    check("rerun_mesh_run_drop", 64'(mesh_run), 64'd0);
    send_record(5'd3, 4'h0, 32'h0000_AAAA, 3);
    send_record(5'd5, 4'h1, 32'h0000_5555, 0);
    wait_run();

    // Out-of-range id: no strobe, sticky error, broadcast still updates.
    start_pass(1);
    send_record(5'd20, 4'h7, 32'h1234_5678, 0);
    wait_run();
    check("id_error_sticky_run", 64'(id_error), 64'd1);

    // Empty pass request in RUN is ignored entirely.
    start_pass(0);
    check("cnt0_mesh_run", 64'(mesh_run), 64'd1);
    check("cnt0_ready", 64'(cfg_ready), 64'd0);
    check("cnt0_id_error", 64'(id_error), 64'd1);

    // New pass from RUN clears the error; a start during LOAD is ignored.
    start_pass(1);
    check("start_clears_err", 64'(id_error), 64'd0);
    check("start_drops_run", 64'(mesh_run), 64'd0);
    check("start_enters_load", 64'(cfg_ready), 64'd1);
    start_pass(5);
    check("start_in_load_ignored", 64'(cfg_ready), 64'd1);
    send_record(5'd15, 4'hC, 32'hCAFE_F00D, 1);
    wait_run();

    // Randomized passes.
    for (int p = 0; p < 25; p++) begin
      int cnt;
      cnt = int'($urandom_range(1, 6));
      start_pass(cnt);
      for (int r = 0; r < cnt; r++) begin
        send_record(ID_W'($urandom_range(0, 19)), 4'($urandom),
                    $urandom, int'($urandom_range(0, 2)));
      end
      wait_run();
      check("rand_id_error", 64'(id_error), 64'(model_err));
    end

    // Asynchronous reset in the middle of a pass.
    start_pass(3);
    send_record(5'd2, 4'h9, 32'hDEAD_BEEF, 0);
    #1;
    reset = 1'b0;
    #1;
    load_q.delete();
    done_q.delete();
    model_active = 1'b0;
    model_rem    = 0;
    model_err    = 1'b0;
    check("arst_pe_load", 64'(pe_load), 64'd0);
    check("arst_pe_instruction", 64'(pe_instruction), 64'd0);
    check("arst_pe_data", 64'(pe_data), 64'd0);
    check("arst_mesh_run", 64'(mesh_run), 64'd0);
    check("arst_prog_busy", 64'(prog_busy), 64'd0);
    check("arst_prog_done", 64'(prog_done), 64'd0);
    check("arst_id_error", 64'(id_error), 64'd0);
    check("arst_cfg_ready", 64'(cfg_ready), 64'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ready", 64'(cfg_ready), 64'd0);
      check("post_rst_busy", 64'(prog_busy), 64'd0);
    end
    @(posedge clk);
    #1;
    start_pass(1);
    send_record(5'd0, 4'h3, 32'h0BAD_C0DE, 0);
    wait_run();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
